// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial add sequencer: FSM state
// encoding, requester count and default operand width.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int NREQ          = 2;
  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_fa_bit.sv
// One-bit combinational full adder; the single shared slice of the
// bit-serial ripple-carry datapath.
module serial_fa_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_next_o
);

  assign s_o      = a_i ^ b_i ^ c_i;
  assign c_next_o = (a_i & b_i) | ((a_i ^ b_i) & c_i);

endmodule

// File: rtl/serial_add_sequencer.sv
// Two-requester round-robin front end sharing one bit-serial adder; adds
// LSB-first over WIDTH cycles and returns the result on a ready/valid channel.
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_id
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic             grant_id;
  logic             fa_s, fa_c;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant_id  = req_valid[1] & (~req_valid[0] | ~last_q);
    req_ready = '0;
    if (state_q == IDLE && !rst && (|req_valid)) req_ready[grant_id] = 1'b1;
  end

  serial_fa_bit u_fa (
    .a_i      (a_q[idx_q]),
    .b_i      (b_q[idx_q]),
    .c_i      (carry_q),
    .s_o      (fa_s),
    .c_next_o (fa_c)
  );

  // NOTE: every signal assigned here gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    id_d    = id_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|(req_valid & req_ready)) begin
          a_d     = req_a[grant_id*WIDTH +: WIDTH];
          b_d     = req_b[grant_id*WIDTH +: WIDTH];
          carry_d = req_cin[grant_id];
          id_d    = grant_id;
          last_d  = grant_id;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[idx_q] = fa_s;
        carry_d      = fa_c;
        if (idx_q == CNT_W'(WIDTH - 1)) begin
          cout_d  = fa_c;
          state_d = RESP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench: a transaction-level model (arbitration rule, integer
// sums, response queue) checks every cycle; directed cases plus random traffic.
module tb_serial_add_sequencer;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic [1:0]     req_cin;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic           rsp_id;

  always #5 clk = ~clk;

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding operation at most, expected results
  // computed with integer arithmetic from the operands seen at accept time.
  typedef struct {
    int sum;
    int cout;
    int id;
  } rsp_t;

  rsp_t exp_q[$];
  int   grant_log[$];
  bit   busy       = 1'b0;
  bit   seen_valid = 1'b0;
  int   lat        = 0;
  int   m_last     = 1;
  int   gid;
  int   full;
  logic [1:0] exp_rdy;

  always @(negedge clk) begin
    if (rst) begin
      check("rdy_in_rst", req_ready, 0);
      busy       = 1'b0;
      seen_valid = 1'b0;
      m_last     = 1;
      exp_q.delete();
    end else if (busy) begin
      check("rdy_busy", req_ready, 0);
      if (!seen_valid) begin
        lat++;
        check("rsp_latency", rsp_valid, (lat == W + 1));
        if (rsp_valid) seen_valid = 1'b1;
      end
      if (seen_valid) begin
        check("rsp_valid_hold", rsp_valid, 1);
        check("rsp_sum", rsp_sum, exp_q[0].sum);
        check("rsp_cout", rsp_cout, exp_q[0].cout);
        check("rsp_id", rsp_id, exp_q[0].id);
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          busy = 1'b0;
        end
      end
    end else begin
      check("rsp_idle", rsp_valid, 0);
      if (req_valid == 2'b00)      gid = -1;
      else if (req_valid == 2'b01) gid = 0;
      else if (req_valid == 2'b10) gid = 1;
      else                         gid = (m_last == 1) ? 0 : 1;
      exp_rdy = (gid < 0) ? 2'b00 : ((gid == 0) ? 2'b01 : 2'b10);
      check("grant", req_ready, exp_rdy);
      if (gid >= 0) begin
        full = int'(req_a[gid*W +: W]) + int'(req_b[gid*W +: W]) + int'(req_cin[gid]);
        exp_q.push_back('{sum: full % (1 << W), cout: full / (1 << W), id: gid});
        busy       = 1'b1;
        seen_valid = 1'b0;
        lat        = 0;
        m_last     = gid;
        grant_log.push_back(gid);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_rsp();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("rsp_timeout", 0, 1);
  endtask

  task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
    req_cin[r]      = cin;
  endtask

  task automatic one_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input int exp_sum, input int exp_cout);
    set_req(r, a, b, cin);
    req_valid    = 2'b00;
    req_valid[r] = 1'b1;
    tick();
    req_valid = 2'b00;
    wait_rsp();
    check("dir_sum", rsp_sum, exp_sum);
    check("dir_cout", rsp_cout, exp_cout);
    check("dir_id", rsp_id, r);
    @(posedge clk);
    #1;
  endtask

  initial begin #100000; $display("FAIL watchdog expired"); $fatal(1); end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = 1'b1;
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", rsp_valid, 0);
    check("rst_sum", rsp_sum, 0);
    check("rst_cout", rsp_cout, 0);
    check("rst_id", rsp_id, 0);
    check("rst_ready", req_ready, 0);
    tick();

    // Basic sums including all-ones boundary.
    one_op(0, 4'h5, 4'h3, 1'b0, 8'h8, 0);
    one_op(1, 4'hF, 4'h1, 1'b0, 8'h0, 1);
    one_op(1, 4'hF, 4'hF, 1'b1, 8'hF, 1);

    // Tie held high: alternating grants starting with requester 0.
    do_reset();
    grant_log.delete();
    set_req(0, 4'h2, 4'h7, 1'b0);
    set_req(1, 4'hA, 4'h9, 1'b1);
    req_valid = 2'b11;
    for (int i = 0; i < 100 && grant_log.size() < 4; i++) tick();
    if (grant_log.size() < 4) check("grant_timeout", grant_log.size(), 4);
    else begin
      check("order0", grant_log[0], 0);
      check("order1", grant_log[1], 1);
      check("order2", grant_log[2], 0);
      check("order3", grant_log[3], 1);
    end

    // Backpressure: response held three extra cycles, request kept pending.
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 4'hC, 4'h6, 1'b1);
    req_valid = 2'b01;
    tick();
    wait_rsp();
    check("bp_sum", rsp_sum, 4'h3);
    check("bp_cout", rsp_cout, 1);
    tick(3);
    check("bp_still_valid", rsp_valid, 1);
    check("bp_no_ready", req_ready, 0);
    rsp_ready = 1'b1;
    tick(2);
    req_valid = 2'b00;
    wait_rsp();
    tick();

    // Reset in the middle of an add, with the request still valid.
    do_reset();
    set_req(0, 4'h9, 4'h8, 1'b1);
    req_valid = 2'b01;
    tick(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_reaccept", req_ready, 2'b01);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    wait_rsp();
    check("mid_rst_sum", rsp_sum, 4'h2);
    check("mid_rst_cout", rsp_cout, 1);
    tick();

    // Tie right after reset goes to requester 0.
    do_reset();
    set_req(0, 4'h1, 4'h1, 1'b0);
    set_req(1, 4'h4, 4'h4, 1'b0);
    req_valid = 2'b11;
    @(negedge clk);
    check("tie_after_rst", req_ready, 2'b01);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    wait_rsp();
    tick();

    // Operands change while the add is in progress.
    set_req(0, 4'h3, 4'h4, 1'b0);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    repeat (3) begin
      req_a   = 8'($urandom);
      req_b   = 8'($urandom);
      req_cin = 2'($urandom);
      tick();
    end
    wait_rsp();
    check("frozen_sum", rsp_sum, 4'h7);
    check("frozen_cout", rsp_cout, 0);
    tick();

    // Random traffic with occasional resets and backpressure.
    for (int i = 0; i < 500; i++) begin
      req_valid = 2'($urandom);
      req_a     = 8'($urandom);
      req_b     = 8'($urandom);
      req_cin   = 2'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst       = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    tick(20);
    check("drained", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
